// File: rtl/change_payout.sv
// change_payout: coin payout unit for the vending controller.
// Pays a change request (in quarters) with the fewest coins, preferring
// dollar coins. Each coin is confirmed on the chute sensor before the next
// one is selected. Tube inventory is tracked, shortfalls are reported, and
// a coin that never reaches the sensor latches a jam fault.
module change_payout #(
  parameter int AMT_W     = 8,
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Change_Req,
  input  logic [AMT_W-1:0] Change_Amount,
  output logic             Ready,
  input  logic             Refill,
  input  logic [CNT_W-1:0] Refill_Dollars,
  input  logic [CNT_W-1:0] Refill_Quarters,
  input  logic             Coin_Sense,
  output logic             Eject_Dollar,
  output logic             Eject_Quarter,
  output logic             Done,
  output logic             Short,
  output logic [AMT_W-1:0] Owed,
  output logic             Fault,
  output logic [CNT_W-1:0] Dollar_Count,
  output logic [CNT_W-1:0] Quarter_Count
);

  // The one timer is shared by PULSE, WAIT_SENSE and GAP, so it must hold
  // the largest of the three terminal counts.
  localparam int TMAX_PG = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TMAX    = (TIMEOUT > TMAX_PG) ? TIMEOUT : TMAX_PG;
  localparam int TMR_W   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_WAIT   = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  state_e             state_q,     state_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   dcnt_q,      dcnt_d;
  logic [CNT_W-1:0]   qcnt_q,      qcnt_d;
  logic               dollar_q,    dollar_d;
  logic               sensed_q,    sensed_d;
  logic [TMR_W-1:0]   timer_q,     timer_d;
  logic               short_q,     short_d;
  logic [AMT_W-1:0]   owed_q,      owed_d;
  logic               fault_q,     fault_d;
  logic               sense_ok_s;

  // Saturating add: a full tube stays full rather than wrapping to empty.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Decrement that holds at zero.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] a);
    if (a == {CNT_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return a - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Coin value in quarters, never taking Remaining below zero.
  function automatic logic [AMT_W-1:0] sub_coin(input logic [AMT_W-1:0] r,
                                                input logic             is_dollar);
    logic [AMT_W-1:0] v;
    v = is_dollar ? AMT_W'(4) : AMT_W'(1);
    if (r >= v) begin
      return r - v;
    end else begin
      return {AMT_W{1'b0}};
    end
  endfunction

  // First chute sense for the coin in flight; later senses are ignored.
  assign sense_ok_s = Coin_Sense && !sensed_q &&
                      ((state_q == S_PULSE) || (state_q == S_WAIT));

  // Next-state, inventory, remainder and status computation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dcnt_d      = dcnt_q;
    qcnt_d      = qcnt_q;
    dollar_d    = dollar_q;
    sensed_d    = sensed_q;
    timer_d     = timer_q;
    short_d     = short_q;
    owed_d      = owed_q;
    fault_d     = fault_q;

    if (sense_ok_s) begin
      sensed_d    = 1'b1;
      remaining_d = sub_coin(remaining_q, dollar_q);
      if (dollar_q) begin
        dcnt_d = sat_dec(dcnt_q);
      end else begin
        qcnt_d = sat_dec(qcnt_q);
      end
    end else begin
      sensed_d = sensed_q;
    end

    case (state_q)
      S_IDLE: begin
        if (Refill) begin
          dcnt_d  = sat_add(dcnt_q, Refill_Dollars);
          qcnt_d  = sat_add(qcnt_q, Refill_Quarters);
          fault_d = 1'b0;
        end else begin
          fault_d = fault_q;
        end
        if (Change_Req) begin
          remaining_d = Change_Amount;
          short_d     = 1'b0;
          owed_d      = {AMT_W{1'b0}};
          state_d     = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        timer_d  = {TMR_W{1'b0}};
        sensed_d = 1'b0;
        if ((remaining_q >= AMT_W'(4)) && (dcnt_q != {CNT_W{1'b0}})) begin
          dollar_d = 1'b1;
          state_d  = S_PULSE;
        end else if ((remaining_q != {AMT_W{1'b0}}) && (qcnt_q != {CNT_W{1'b0}})) begin
          dollar_d = 1'b0;
          state_d  = S_PULSE;
        end else begin
          short_d = (remaining_q != {AMT_W{1'b0}});
          owed_d  = remaining_q;
          state_d = S_FINISH;
        end
      end
      S_PULSE: begin
        if (timer_q == TMR_W'(PULSE_LEN - 1)) begin
          timer_d = {TMR_W{1'b0}};
          if (sensed_q || sense_ok_s) begin
            state_d = S_GAP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT: begin
        if (sense_ok_s) begin
          timer_d = {TMR_W{1'b0}};
          state_d = S_GAP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // Jammed coin: its tube can no longer be trusted, so empty it.
          fault_d = 1'b1;
          short_d = 1'b1;
          owed_d  = remaining_q;
          state_d = S_FAULT;
          if (dollar_q) begin
            dcnt_d = {CNT_W{1'b0}};
          end else begin
            qcnt_d = {CNT_W{1'b0}};
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (timer_q == TMR_W'(GAP_LEN - 1)) begin
          timer_d = {TMR_W{1'b0}};
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any payout in progress.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      remaining_q <= {AMT_W{1'b0}};
      dcnt_q      <= {CNT_W{1'b0}};
      qcnt_q      <= {CNT_W{1'b0}};
      dollar_q    <= 1'b0;
      sensed_q    <= 1'b0;
      timer_q     <= {TMR_W{1'b0}};
      short_q     <= 1'b0;
      owed_q      <= {AMT_W{1'b0}};
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dcnt_q      <= dcnt_d;
      qcnt_q      <= qcnt_d;
      dollar_q    <= dollar_d;
      sensed_q    <= sensed_d;
      timer_q     <= timer_d;
      short_q     <= short_d;
      owed_q      <= owed_d;
      fault_q     <= fault_d;
    end
  end

  // Outputs are pure state decode or register copies.
  assign Ready         = (state_q == S_IDLE);
  assign Eject_Dollar  = (state_q == S_PULSE) && dollar_q;
  assign Eject_Quarter = (state_q == S_PULSE) && !dollar_q;
  assign Done          = (state_q == S_FINISH) || (state_q == S_FAULT);
  assign Short         = short_q;
  assign Owed          = owed_q;
  assign Fault         = fault_q;
  assign Dollar_Count  = dcnt_q;
  assign Quarter_Count = qcnt_q;

endmodule

// File: tb/tb_change_payout.sv
// Directed self-checking bench for change_payout.
module tb_change_payout;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Change_Req;
  logic [7:0] Change_Amount;
  logic       Ready;
  logic       Refill;
  logic [7:0] Refill_Dollars;
  logic [7:0] Refill_Quarters;
  logic       Coin_Sense;
  logic       Eject_Dollar;
  logic       Eject_Quarter;
  logic       Done;
  logic       Short;
  logic [7:0] Owed;
  logic       Fault;
  logic [7:0] Dollar_Count;
  logic [7:0] Quarter_Count;

  int checks = 0;
  int errors = 0;

  change_payout dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Change_Req      (Change_Req),
    .Change_Amount   (Change_Amount),
    .Ready           (Ready),
    .Refill          (Refill),
    .Refill_Dollars  (Refill_Dollars),
    .Refill_Quarters (Refill_Quarters),
    .Coin_Sense      (Coin_Sense),
    .Eject_Dollar    (Eject_Dollar),
    .Eject_Quarter   (Eject_Quarter),
    .Done            (Done),
    .Short           (Short),
    .Owed            (Owed),
    .Fault           (Fault),
    .Dollar_Count    (Dollar_Count),
    .Quarter_Count   (Quarter_Count)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic refill(input logic [7:0] d, input logic [7:0] q);
    Refill = 1'b1;
    Refill_Dollars = d;
    Refill_Quarters = q;
    tick();
    Refill = 1'b0;
    Refill_Dollars = 8'd0;
    Refill_Quarters = 8'd0;
  endtask

  task automatic req(input logic [7:0] amt);
    Change_Req = 1'b1;
    Change_Amount = amt;
    tick();
    Change_Req = 1'b0;
    Change_Amount = 8'd0;
  endtask

  // Wait for the next eject, check coin kind and pulse length, then
  // optionally pulse the chute sensor in the first cycle after the pulse.
  task automatic serve(input logic exp_dollar, input logic do_sense, input string tag);
    int n;
    n = 0;
    while (!(Eject_Dollar || Eject_Quarter) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(Eject_Dollar | Eject_Quarter), 32'd1);
    chk({tag, "_kind"}, 32'(Eject_Dollar), 32'(exp_dollar));
    n = 0;
    while ((Eject_Dollar || Eject_Quarter) && n < 10) begin
      chk({tag, "_both"}, 32'(Eject_Dollar & Eject_Quarter), 32'd0);
      tick();
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'd4);
    if (do_sense) begin
      Coin_Sense = 1'b1;
      tick();
      Coin_Sense = 1'b0;
    end
  endtask

  // Wait for Done and check the reported status and inventory.
  task automatic finish_check(input string tag, input logic exp_short,
                              input logic [7:0] exp_owed, input logic [7:0] exp_d,
                              input logic [7:0] exp_q, input logic exp_fault,
                              input int exp_wait);
    int n;
    n = 0;
    while (!Done && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    if (exp_wait >= 0) begin
      chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
    end
    chk({tag, "_short"}, 32'(Short), 32'(exp_short));
    chk({tag, "_owed"}, 32'(Owed), 32'(exp_owed));
    chk({tag, "_dcnt"}, 32'(Dollar_Count), 32'(exp_d));
    chk({tag, "_qcnt"}, 32'(Quarter_Count), 32'(exp_q));
    chk({tag, "_fault"}, 32'(Fault), 32'(exp_fault));
    tick();
    chk({tag, "_done1"}, 32'(Done), 32'd0);
    chk({tag, "_ready"}, 32'(Ready), 32'd1);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    Reset = 1'b0;
    Change_Req = 1'b0;
    Change_Amount = 8'd0;
    Refill = 1'b0;
    Refill_Dollars = 8'd0;
    Refill_Quarters = 8'd0;
    Coin_Sense = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_ejd", 32'(Eject_Dollar), 32'd0);
    chk("rst_ejq", 32'(Eject_Quarter), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_short", 32'(Short), 32'd0);
    chk("rst_owed", 32'(Owed), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    chk("rst_dcnt", 32'(Dollar_Count), 32'd0);
    chk("rst_qcnt", 32'(Quarter_Count), 32'd0);
    Reset = 1'b1;
    tick();

    // 1: D=2,Q=3, request 6 -> D,Q,Q
    refill(8'd2, 8'd3);
    chk("t1_dcnt0", 32'(Dollar_Count), 32'd2);
    chk("t1_qcnt0", 32'(Quarter_Count), 32'd3);
    req(8'd6);
    serve(1'b1, 1'b1, "t1_c1");
    serve(1'b0, 1'b1, "t1_c2");
    serve(1'b0, 1'b1, "t1_c3");
    finish_check("t1", 1'b0, 8'd0, 8'd1, 8'd1, 1'b0, -1);

    // 2: D=0,Q=2, request 5 -> two quarters, short by 3
    do_reset();
    refill(8'd0, 8'd2);
    req(8'd5);
    serve(1'b0, 1'b1, "t2_c1");
    serve(1'b0, 1'b1, "t2_c2");
    finish_check("t2", 1'b1, 8'd3, 8'd0, 8'd0, 1'b0, -1);

    // 3: D=1,Q=8, request 7 -> D,Q,Q,Q; then request 4 -> four quarters
    refill(8'd1, 8'd8);
    req(8'd7);
    serve(1'b1, 1'b1, "t3_c1");
    serve(1'b0, 1'b1, "t3_c2");
    serve(1'b0, 1'b1, "t3_c3");
    serve(1'b0, 1'b1, "t3_c4");
    finish_check("t3a", 1'b0, 8'd0, 8'd0, 8'd5, 1'b0, -1);
    req(8'd4);
    serve(1'b0, 1'b1, "t3_c5");
    serve(1'b0, 1'b1, "t3_c6");
    serve(1'b0, 1'b1, "t3_c7");
    serve(1'b0, 1'b1, "t3_c8");
    finish_check("t3b", 1'b0, 8'd0, 8'd0, 8'd1, 1'b0, -1);

    // 4: Q=5, request 2, no sense -> jam fault after the timeout
    refill(8'd0, 8'd4);
    chk("t4_qcnt0", 32'(Quarter_Count), 32'd5);
    req(8'd2);
    serve(1'b0, 1'b0, "t4_c1");
    finish_check("t4", 1'b1, 8'd2, 8'd0, 8'd0, 1'b1, 16);
    chk("t4_fault_held", 32'(Fault), 32'd1);
    refill(8'd0, 8'd0);
    chk("t4_fault_clr", 32'(Fault), 32'd0);

    // 5: zero request, saturating refill, requests while busy ignored
    req(8'd0);
    chk("t5_done_sel", 32'(Done), 32'd0);
    chk("t5_ready_sel", 32'(Ready), 32'd0);
    chk("t5_short_clr", 32'(Short), 32'd0);
    tick();
    chk("t5_done", 32'(Done), 32'd1);
    chk("t5_short", 32'(Short), 32'd0);
    chk("t5_noej", 32'(Eject_Dollar | Eject_Quarter), 32'd0);
    tick();
    chk("t5_ready", 32'(Ready), 32'd1);
    refill(8'd0, 8'd100);
    chk("t5_q100", 32'(Quarter_Count), 32'd100);
    refill(8'd0, 8'd200);
    chk("t5_qsat", 32'(Quarter_Count), 32'd255);
    req(8'd1);
    serve(1'b0, 1'b0, "t5_c1");
    Coin_Sense = 1'b1;
    Change_Req = 1'b1;
    Change_Amount = 8'd8;
    Refill = 1'b1;
    Refill_Dollars = 8'd5;
    tick();
    Coin_Sense = 1'b0;
    Change_Req = 1'b0;
    Change_Amount = 8'd0;
    Refill = 1'b0;
    Refill_Dollars = 8'd0;
    finish_check("t5b", 1'b0, 8'd0, 8'd0, 8'd254, 1'b0, -1);
    repeat (3) begin
      tick();
      chk("t5_idle", 32'({Ready, Eject_Dollar, Eject_Quarter}), 32'd4);
    end

    // 6: reset in the middle of a dollar pulse
    refill(8'd3, 8'd0);
    req(8'd4);
    tick();
    chk("t6_ejd", 32'(Eject_Dollar), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("t6_ejd_off", 32'(Eject_Dollar), 32'd0);
    chk("t6_done", 32'(Done), 32'd0);
    chk("t6_dcnt", 32'(Dollar_Count), 32'd0);
    chk("t6_qcnt", 32'(Quarter_Count), 32'd0);
    repeat (2) begin
      tick();
      chk("t6_done_rst", 32'(Done), 32'd0);
    end
    Reset = 1'b1;
    tick();
    chk("t6_ready", 32'(Ready), 32'd1);
    chk("t6_done_rel", 32'(Done), 32'd0);
    chk("t6_noej", 32'(Eject_Dollar | Eject_Quarter), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
